// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares one single-port frame-buffer/data RAM between the VGA pixel fetch
//   and CPU loads/stores. The word for the next scan pixel is fetched one
//   pixel period ahead and presented, registered, for the whole following
//   period. Video reads always win the RAM; the CPU waits via req/ready.
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   pixel_en, x, y, vid_en     scan timing/position, video enable
//   pix_data, pix_valid        registered pixel word and in-image flag
//   cpu_req/we/addr/wdata      CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready       load data and one-cycle completion pulse
//   mem_addr/we/wdata          RAM request (combinational from the grant)
//   mem_rdata                  RAM read data, one cycle after mem_addr
module fb_mem_arbiter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned RECT_X   = 120,
  parameter int unsigned RECT_Y   = 0,
  parameter int unsigned RECT_W   = 320,
  parameter int unsigned RECT_H   = 200,
  parameter int unsigned FB_BASE  = 0,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              vid_en,
  output logic [31:0]       pix_data,
  output logic              pix_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [31:0]         rdata_q;
  logic                cap_q;
  logic [31:0]         fetch_q;
  logic                inbuf_q;

  logic [9:0]          nx, ny;
  logic [31:0]         off_x, off_y;
  logic                in_rect;
  logic [ADDR_W-1:0]   vid_addr;
  logic                vid_slot;
  logic                grant;

  // Next scan position, wrapping at line and frame end.
  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == 10'(H_ACTIVE - 1)) begin
      nx = '0;
      ny = (y == 10'(V_ACTIVE - 1)) ? '0 : y + 10'd1;
    end
  end

  // Unsigned offsets: positions left of/above the rectangle wrap to huge
  // values, so a single upper-bound compare covers both edges.
  assign off_x    = 32'(nx) - RECT_X;
  assign off_y    = 32'(ny) - RECT_Y;
  assign in_rect  = (off_x < RECT_W) && (off_y < RECT_H);
  assign vid_addr = ADDR_W'(FB_BASE + off_y * RECT_W + off_x);

  // Both request paths are gated by reset so the combinational RAM outputs
  // read as zero while reset is held.
  assign vid_slot = reset & pixel_en & vid_en & in_rect;
  // The capture cycle after a video slot only consumes mem_rdata; the
  // address port is free then, so the CPU may be granted in it.
  assign grant    = reset & (state_q == S_IDLE) & cpu_req & ~vid_slot;

  always_comb begin
    state_d   = state_q;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vid_slot) begin
      mem_addr = vid_addr;
    end else if (grant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
      state_d   = S_WAIT;
    end
    if (state_q == S_WAIT) state_d = S_IDLE;
  end

  assign cpu_ready = (state_q == S_WAIT);
  assign cpu_rdata = (cpu_ready && !we_q) ? mem_rdata : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      cap_q     <= 1'b0;
      fetch_q   <= '0;
      inbuf_q   <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
      cap_q   <= vid_slot;
      if (grant) we_q <= cpu_we;
      if (cpu_ready && !we_q) rdata_q <= mem_rdata;
      if (pixel_en && !vid_slot) inbuf_q <= 1'b0;
      if (cap_q) begin
        fetch_q <= mem_rdata;
        inbuf_q <= 1'b1;
      end
      if (pixel_en) begin
        pix_data  <= fetch_q;
        pix_valid <= inbuf_q & vid_en;
      end
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter
//   Directed bench for fb_mem_arbiter with a one-cycle-latency RAM model.
//   Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
module tb_fb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_en;
  logic [9:0]  x, y;
  logic        vid_en;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] ram [0:65535];

  always #5 clk = ~clk;

  fb_mem_arbiter #(
    .H_ACTIVE(640), .V_ACTIVE(480), .RECT_X(120), .RECT_Y(0),
    .RECT_W(320), .RECT_H(200), .FB_BASE(0), .ADDR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .x(x), .y(y),
    .vid_en(vid_en), .pix_data(pix_data), .pix_valid(pix_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    ram[0]      = 32'h00AABBCC;
    ram[1]      = 32'h00112233;
    ram[320]    = 32'h00CAFE01;
    ram[1919]   = 32'h00778899;
    ram[63680]  = 32'h00445566;
    ram[16'h0010] = 32'hA5A50010;
    ram[16'h1234] = 32'h12345678;
    mem_rdata = '0;

    reset = 1'b0; pixel_en = 1'b0; x = '0; y = '0; vid_en = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) cyc();
    #1;
    chk("rst_pix_data", pix_data, 32'h0);
    chk("rst_pix_valid", 32'(pix_valid), 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b1;
    cyc();

    // Image pixel (120,0) fetched at x=119, shown one period later.
    pixel_en = 1'b1; x = 10'd119; y = 10'd0;
    #1;
    chk("t2_addr", 32'(mem_addr), 32'd0);
    chk("t2_we", 32'(mem_we), 32'h0);
    cyc(); pixel_en = 1'b0;
    cyc(); pixel_en = 1'b1; x = 10'd120;
    #1;
    chk("t2_addr_next", 32'(mem_addr), 32'd1);
    cyc();
    chk("t2_pix_data", pix_data, 32'h00AABBCC);
    chk("t2_pix_valid", 32'(pix_valid), 32'h1);
    pixel_en = 1'b0;
    cyc();

    // Last image row, right edge, and pixels just outside the rectangle.
    pixel_en = 1'b1; x = 10'd119; y = 10'd199;
    #1;
    chk("t3_addr_last_row", 32'(mem_addr), 32'd63680);
    cyc();
    chk("t3_pix_data_prev", pix_data, 32'h00112233);
    pixel_en = 1'b0;
    cyc(); pixel_en = 1'b1; x = 10'd438; y = 10'd5;
    #1;
    chk("t3_addr_right_edge", 32'(mem_addr), 32'd1919);
    cyc();
    chk("t3_pix_data", pix_data, 32'h00445566);
    chk("t3_pix_valid", 32'(pix_valid), 32'h1);
    pixel_en = 1'b0;
    cyc(); pixel_en = 1'b1; x = 10'd439; y = 10'd0;
    #1;
    chk("t3_x440_we", 32'(mem_we), 32'h0);
    chk("t3_x440_addr_hold", 32'(mem_addr), 32'd1919);
    cyc();
    chk("t3_pix_data_edge", pix_data, 32'h00778899);
    pixel_en = 1'b0;
    cyc(); pixel_en = 1'b1; x = 10'd119; y = 10'd200;
    #1;
    chk("t3_y200_addr_hold", 32'(mem_addr), 32'd1919);
    cyc();
    chk("t3_pix_valid_out", 32'(pix_valid), 32'h0);
    pixel_en = 1'b0;
    cyc();

    // CPU load collides with a video slot: video first, CPU next cycle.
    pixel_en = 1'b1; x = 10'd119; y = 10'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    #1;
    chk("t4_vid_addr", 32'(mem_addr), 32'd320);
    chk("t4_ready0", 32'(cpu_ready), 32'h0);
    cyc(); pixel_en = 1'b0;
    #1;
    chk("t4_cpu_addr", 32'(mem_addr), 32'h1234);
    chk("t4_cpu_we", 32'(mem_we), 32'h0);
    chk("t4_ready1", 32'(cpu_ready), 32'h0);
    cyc();
    chk("t4_ready2", 32'(cpu_ready), 32'h1);
    chk("t4_rdata", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    cyc();
    chk("t4_ready_drop", 32'(cpu_ready), 32'h0);

    // CPU store outside the image: granted in the pixel_en cycle itself.
    pixel_en = 1'b1; x = 10'd500; y = 10'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 32'hDEADBEEF;
    #1;
    chk("t5_we", 32'(mem_we), 32'h1);
    chk("t5_addr", 32'(mem_addr), 32'h2000);
    chk("t5_wdata", mem_wdata, 32'hDEADBEEF);
    cyc(); pixel_en = 1'b0;
    #1;
    chk("t5_ready", 32'(cpu_ready), 32'h1);
    chk("t5_wait_we", 32'(mem_we), 32'h0);
    chk("t5_store_rdata_kept", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    chk("t5_readback_addr", 32'(mem_addr), 32'h2000);
    cyc();
    chk("t5_readback", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    cyc();

    // Video disabled: CPU owns every slot, one ready every two clocks.
    vid_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    x = 10'd119; y = 10'd2;
    for (int i = 0; i < 8; i++) begin
      pixel_en = (i % 2 == 0);
      #1;
      if (i % 2 == 0) begin
        chk("t6_grant_addr", 32'(mem_addr), 32'h0010);
        chk("t6_ready_lo", 32'(cpu_ready), 32'h0);
      end else begin
        chk("t6_ready_hi", 32'(cpu_ready), 32'h1);
        chk("t6_rdata", cpu_rdata, 32'hA5A50010);
      end
      if (i >= 1) chk("t6_pix_valid", 32'(pix_valid), 32'h0);
      cyc();
    end
    cpu_req = 1'b0; pixel_en = 1'b0;
    cyc();

    // Reset mid-frame with a valid pixel on screen and a CPU request up.
    vid_en = 1'b1; pixel_en = 1'b1; x = 10'd119; y = 10'd0;
    cyc(); pixel_en = 1'b0;
    cyc(); pixel_en = 1'b1; x = 10'd120;
    cyc();
    chk("t1_pre_valid", 32'(pix_valid), 32'h1);
    pixel_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    #1;
    reset = 1'b0;
    #1;
    chk("t1_pix_data", pix_data, 32'h0);
    chk("t1_pix_valid", 32'(pix_valid), 32'h0);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    chk("t1_mem_wdata", mem_wdata, 32'h0);
    chk("t1_rdata", cpu_rdata, 32'h0);
    repeat (2) begin
      cyc();
      chk("t1_no_ready", 32'(cpu_ready), 32'h0);
    end
    reset = 1'b1;
    #1;
    chk("t1_grant_addr", 32'(mem_addr), 32'h1234);
    cyc();
    chk("t1_ready", 32'(cpu_ready), 32'h1);
    chk("t1_load", cpu_rdata, 32'h12345678);
    cpu_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
